// File: rtl/sequence_detector.sv
// Serial detector for the pattern 0,1,0*,1 (non-overlapping) with a two-digit BCD
// hit counter shown on active-low 7-segment outputs. Define COUNT_SATURATE_EN to hold at 99.
module sequence_detector (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       sig_to_test,
    output logic [6:0] disp0,
    output logic [6:0] disp1,
    output logic       z
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GOT0  = 2'd1,
        GOT01 = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] ones_nxt;
    logic [3:0] tens_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = sig_to_test ? IDLE  : GOT0;
            GOT0:    state_nxt = sig_to_test ? GOT01 : GOT0;
            GOT01:   state_nxt = sig_to_test ? IDLE  : GOT01;
            default: state_nxt = IDLE;
        endcase
    end

    // z already folds in ena and ~rst, so it doubles as the counter enable.
    assign z = (state == GOT01) & sig_to_test & ena & ~rst;

    always_comb begin
        ones_nxt = ones;
        tens_nxt = tens;
        if (ones == 4'd9) begin
            if (tens == 4'd9) begin
`ifdef COUNT_SATURATE_EN
                ones_nxt = 4'd9;
                tens_nxt = 4'd9;
`else
                ones_nxt = '0;
                tens_nxt = '0;
`endif
            end else begin
                ones_nxt = '0;
                tens_nxt = tens + 4'd1;
            end
        end else begin
            ones_nxt = ones + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ones <= '0;
            tens <= '0;
        end else if (z) begin
            ones <= ones_nxt;
            tens <= tens_nxt;
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    assign disp0 = seg_decode(ones);
    assign disp1 = seg_decode(tens);

endmodule

// File: tb/tb_sequence_detector.sv
// Directed bench for sequence_detector: hand-computed z pulses and display codes,
// covering reset priority, non-overlap, enable hold and 99->00 wrap / saturation.
module tb_sequence_detector;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       sig_to_test;
    logic [6:0] disp0;
    logic [6:0] disp1;
    logic       z;

    int unsigned vectors;
    int unsigned miscompares;

    sequence_detector dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .sig_to_test (sig_to_test),
        .disp0       (disp0),
        .disp1       (disp1),
        .z           (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, check the Mealy output before the edge, then clock.
    task automatic apply(input logic r, input logic en, input logic s, input logic exp_z,
                         input string tag);
        rst         = r;
        ena         = en;
        sig_to_test = s;
        #1;
        check(tag, {6'b0, z}, {6'b0, exp_z});
        @(posedge clk);
        #1;
    endtask

    task automatic detect_once(input string tag);
        apply(1'b0, 1'b1, 1'b0, 1'b0, tag);
        apply(1'b0, 1'b1, 1'b1, 1'b0, tag);
        apply(1'b0, 1'b1, 1'b1, 1'b1, tag);
    endtask

    logic [23:0] stream;
    logic [23:0] exp_pulse;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        ena         = 1'b1;
        sig_to_test = 1'b1;
        @(posedge clk);
        #1;

        // Reset held with ena and a 1 present: z must stay low, display "00".
        apply(1'b1, 1'b1, 1'b1, 1'b0, "rst_z");
        check("rst_disp0", disp0, 7'h40);
        check("rst_disp1", disp1, 7'h40);

        // Long stream: pulses at indices 6, 13, 19, 23 (index 0 first).
        stream    = 24'b000100110001011101010011;
        exp_pulse = 24'b0;
        exp_pulse[23-6]  = 1'b1;
        exp_pulse[23-13] = 1'b1;
        exp_pulse[23-19] = 1'b1;
        exp_pulse[23-23] = 1'b1;
        for (int i = 23; i >= 0; i--) begin
            apply(1'b0, 1'b1, stream[i], exp_pulse[i], "stream_z");
        end
        check("stream_disp1", disp1, 7'h40);
        check("stream_disp0", disp0, 7'h19);

        // 0,1,1: pulse on third bit, display updates the cycle after.
        apply(1'b1, 1'b1, 1'b0, 1'b0, "rst2");
        apply(1'b0, 1'b1, 1'b0, 1'b0, "s011_b0");
        apply(1'b0, 1'b1, 1'b1, 1'b0, "s011_b1");
        rst = 1'b0; ena = 1'b1; sig_to_test = 1'b1;
        #1;
        check("s011_z", {6'b0, z}, 7'd1);
        check("s011_disp0_before", disp0, 7'h40);
        @(posedge clk);
        #1;
        check("s011_disp0", disp0, 7'h79);
        check("s011_disp1", disp1, 7'h40);

        // 0,1,0,1,1: one pulse on fourth bit; completing 1 not reused.
        apply(1'b1, 1'b1, 1'b0, 1'b0, "rst3");
        apply(1'b0, 1'b1, 1'b0, 1'b0, "ov_b0");
        apply(1'b0, 1'b1, 1'b1, 1'b0, "ov_b1");
        apply(1'b0, 1'b1, 1'b0, 1'b0, "ov_b2");
        apply(1'b0, 1'b1, 1'b1, 1'b1, "ov_b3");
        apply(1'b0, 1'b1, 1'b1, 1'b0, "ov_b4");
        check("ov_disp0", disp0, 7'h79);

        // Enable low in GOT01 with a 1 present: no pulse, count held.
        apply(1'b0, 1'b1, 1'b0, 1'b0, "ena_b0");
        apply(1'b0, 1'b1, 1'b1, 1'b0, "ena_b1");
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b0, "ena_hold_z");
        end
        check("ena_hold_disp0", disp0, 7'h79);
        apply(1'b0, 1'b1, 1'b1, 1'b1, "ena_resume_z");
        check("ena_resume_disp0", disp0, 7'h24);

        // Reset collides with a completing 1: no pulse, count cleared, pattern discarded.
        apply(1'b0, 1'b1, 1'b0, 1'b0, "rc_b0");
        apply(1'b0, 1'b1, 1'b1, 1'b0, "rc_b1");
        apply(1'b1, 1'b1, 1'b1, 1'b0, "rc_rst_z");
        check("rc_disp0", disp0, 7'h40);
        check("rc_disp1", disp1, 7'h40);
        apply(1'b0, 1'b1, 1'b1, 1'b0, "rc_after_1");
        detect_once("rc_redetect");
        check("rc_redetect_disp0", disp0, 7'h79);

        // 100 detections from zero: checks tens carry, 99, then wrap or saturate.
        apply(1'b1, 1'b1, 1'b0, 1'b0, "rst4");
        for (int n = 1; n <= 100; n++) begin
            detect_once("cnt_z");
            if (n == 10) begin
                check("cnt10_disp1", disp1, 7'h79);
                check("cnt10_disp0", disp0, 7'h40);
            end
            if (n == 57) begin
                check("cnt57_disp1", disp1, 7'h12);
                check("cnt57_disp0", disp0, 7'h78);
            end
            if (n == 99) begin
                check("cnt99_disp1", disp1, 7'h10);
                check("cnt99_disp0", disp0, 7'h10);
            end
        end
`ifdef COUNT_SATURATE_EN
        check("cnt100_disp1", disp1, 7'h10);
        check("cnt100_disp0", disp0, 7'h10);
        detect_once("sat_extra_z");
        check("sat_extra_disp0", disp0, 7'h10);
`else
        check("cnt100_disp1", disp1, 7'h40);
        check("cnt100_disp0", disp0, 7'h40);
        detect_once("wrap_extra_z");
        check("wrap_extra_disp0", disp0, 7'h79);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sequence_detector.md
SEQUENCE_DETECTOR -- requirements
Module: sequence_detector

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 Port `clk`: input, 1 bit; sole clock, all state updates on its rising edge.
REQ-003 Port `rst`: input, 1 bit; synchronous, active-high reset.
REQ-004 Port `ena`: input, 1 bit; 1 = FSM and counter advance, 0 = all state held.
REQ-005 Port `sig_to_test`: input, 1 bit; serial bit stream sampled every rising `clk` edge.
REQ-006 Port `disp0`: output, 7 bits; active-low 7-segment code of the count ones digit (bit0 = a … bit6 = g).
REQ-007 Port `disp1`: output, 7 bits; active-low 7-segment code of the count tens digit (same bit order).
REQ-008 Port `z`: output, 1 bit; Mealy detection flag.

Function
REQ-009 Target pattern SHALL be 0,1,0*,1, where 0* is zero or more zeros; "011", "0101" and "01001" SHALL all match.
REQ-010 The FSM SHALL have three states:
- IDLE: reset state, waiting for a 0.
- GOT0: a 0 has been seen.
- GOT01: "01" plus any following zeros has been seen.
REQ-011 Transitions SHALL apply only when `ena`=1:
- IDLE: 0→GOT0, 1→IDLE.
- GOT0: 0→GOT0, 1→GOT01.
- GOT01: 0→GOT01, 1→IDLE.
REQ-012 Detection SHALL be non-overlapping: the completing 1 SHALL NOT be reused, and the FSM SHALL return to IDLE.
REQ-013 `z` SHALL be combinational: z = (state==GOT01) & `sig_to_test` & `ena` & ~`rst`.
REQ-014 On each rising edge with `z`=1, a two-digit BCD count (tens 0–9, ones 0–9) SHALL increment by 1.
REQ-015 On increment, ones SHALL roll 9→0 with a carry into tens.
REQ-016 Without COUNT_SATURATE_EN, the count SHALL wrap from 99 to 00.
REQ-017 The count SHALL change only on detection edges; the count SHALL otherwise hold.
REQ-018 `disp0`/`disp1` SHALL be combinational decodes of the registered digits, so the display updates the cycle after `z`=1.
REQ-019 Digit codes 0–9 (hex, active-low) SHALL be: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10.
REQ-020 When `ena`=0, state and count SHALL hold, and `z` SHALL be 0.

Reset
REQ-021 While `rst`=1 at a rising edge, the state SHALL go to IDLE and the count SHALL go to 00.
REQ-022 Reset SHALL take priority over `ena` and over a simultaneous detection; that detection SHALL NOT be counted.
REQ-023 After reset, `disp0`=`disp1`=7'h40 ("00"), and `z` SHALL be 0 while `rst`=1.
REQ-024 Reset mid-pattern SHALL discard the partial match.

Configuration
REQ-025 With macro COUNT_SATURATE_EN defined, the count SHALL saturate at 99: further detections still pulse `z` but leave the count at 99.
REQ-026 With COUNT_SATURATE_EN undefined, the count SHALL wrap 99→00.

Verification
REQ-027 Reset then bits 000100110001011101010011 (left first, `ena`=1) → `z` pulses at bit indices 6, 13, 19, 23; final count 04; `disp1`=40, `disp0`=19.
REQ-028 Bits 0,1,1 → `z`=1 on the third bit; the display shows 01 on the next cycle.
REQ-029 Bits 0,1,0,1,1 → exactly one pulse (fourth bit); the fifth bit gives no pulse (non-overlap).
REQ-030 In state GOT01, drive `ena`=0 with `sig_to_test`=1 for 3 cycles → `z`=0 and count unchanged; `ena`=1 with 1 → one pulse.
REQ-031 Run 100 detections → count wraps to 00 (displays 40/40); with COUNT_SATURATE_EN → stays 99 (`disp1`=`disp0`=10).
REQ-032 Assert `rst` in the same cycle as a completing 1 → `z`=0, count 00, next 0,1,1 detected normally.
